am4_useq: RTL and testbench

- Microprogram sequencer (Am2910-class) that generates the next microinstruction address for the microcode ROM.
- Its pipeline register drives the bit-slice ALU and look-ahead carry datapath.
- Provides a microPC with incrementer, a loop/counter register R, a LIFO subroutine/loop stack, and 16 next-address instructions.
- Instruction, condition code and branch data (D) come from the microword pipeline register and the status logic.

---
 rtl/am4_useq_pkg.sv | 58 +++++
 rtl/am4_useq_stack.sv | 73 +++++++
 rtl/am4_useq.sv | 207 ++++++++++++++++++++
 tb/tb_am4_useq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/am4_useq_pkg.sv
// am4_useq_pkg: opcodes, select enums and decoded control bundle
// shared by the am4_useq microprogram sequencer and its stack.
package am4_useq_pkg;

  localparam logic [3:0] JZ   = 4'd0;
  localparam logic [3:0] CJS  = 4'd1;
  localparam logic [3:0] JMAP = 4'd2;
  localparam logic [3:0] CJP  = 4'd3;
  localparam logic [3:0] PUSH = 4'd4;
  localparam logic [3:0] JSRP = 4'd5;
  localparam logic [3:0] CJV  = 4'd6;
  localparam logic [3:0] JRP  = 4'd7;
  localparam logic [3:0] RFCT = 4'd8;
  localparam logic [3:0] RPCT = 4'd9;
  localparam logic [3:0] CRTN = 4'd10;
  localparam logic [3:0] CJPP = 4'd11;
  localparam logic [3:0] LDCT = 4'd12;
  localparam logic [3:0] LOOP = 4'd13;
  localparam logic [3:0] CONT = 4'd14;
  localparam logic [3:0] TWB  = 4'd15;

  typedef enum logic [1:0] {
    SRC_PL,
    SRC_MAP,
    SRC_VECT
  } src_e;

  typedef enum logic [2:0] {
    NA_ZERO,
    NA_D,
    NA_UPC,
    NA_R,
    NA_TOS
  } nsel_e;

  typedef struct packed {
    nsel_e nsel;
    src_e  src;
    logic  push;
    logic  pop;
    logic  clr;
    logic  r_ld;
    logic  r_dec;
  } ctl_t;

  function automatic ctl_t ctl_default();
    ctl_t c;
    c.nsel  = NA_UPC;
    c.src   = SRC_PL;
    c.push  = 1'b0;
    c.pop   = 1'b0;
    c.clr   = 1'b0;
    c.r_ld  = 1'b0;
    c.r_dec = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/am4_useq_stack.sv
// am4_useq_stack: SD x AW LIFO. Ports: clk_i, rst_i, push_i, pop_i,
// clr_i, din_i -> tos_o, sp_o (+ ovf_o/unf_o with AM4_USEQ_ERR_EN).
module am4_useq_stack
  import am4_useq_pkg::*;
#(
  parameter int AW  = 12,
  parameter int SD  = 5,
  parameter int SPW = $clog2(SD + 1)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           push_i,
  input  logic           pop_i,
  input  logic           clr_i,
  input  logic [AW-1:0]  din_i,
  output logic [AW-1:0]  tos_o,
  output logic [SPW-1:0] sp_o
`ifdef AM4_USEQ_ERR_EN
  ,
  output logic           ovf_o,
  output logic           unf_o
`endif
);

  logic [AW-1:0]  mem_q [SD];
  logic [SPW-1:0] sp_q;
  logic [SPW-1:0] sp_d;
  logic [SPW-1:0] rd_idx;
  logic [SPW-1:0] wr_idx;
  logic           full;
  logic           empty;

  assign full  = (sp_q == SPW'(SD));
  assign empty = (sp_q == '0);

  // Empty stack reads entry 0; a full stack overwrites its top entry.
  assign rd_idx = empty ? '0 : sp_q - 1'b1;
  assign wr_idx = full ? SPW'(SD - 1) : sp_q;

  assign tos_o = mem_q[rd_idx];
  assign sp_o  = sp_q;

`ifdef AM4_USEQ_ERR_EN
  assign ovf_o = push_i & full;
  assign unf_o = pop_i & empty;
`endif

  always_comb begin
    sp_d = sp_q;
    if (clr_i) begin
      sp_d = '0;
    end else if (push_i) begin
      if (!full) sp_d = sp_q + 1'b1;
    end else if (pop_i) begin
      if (!empty) sp_d = sp_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sp_q <= '0;
      for (int k = 0; k < SD; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      sp_q <= sp_d;
      if (push_i && !clr_i) begin
        mem_q[wr_idx] <= din_i;
      end
    end
  end

endmodule

// File: rtl/am4_useq.sv
// am4_useq: Am2910-class microprogram sequencer. Ports: clk, rst, i, d,
// ccen_n, cc_n, ci, rld_n -> y, full_n, pl_n, map_n, vect_n (+ err with AM4_USEQ_ERR_EN).
module am4_useq
  import am4_useq_pkg::*;
#(
  parameter int AW = 12,
  parameter int SD = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    i,
  input  logic [AW-1:0] d,
  input  logic          ccen_n,
  input  logic          cc_n,
  input  logic          ci,
  input  logic          rld_n,
  output logic [AW-1:0] y,
  output logic          full_n,
  output logic          pl_n,
  output logic          map_n,
  output logic          vect_n
`ifdef AM4_USEQ_ERR_EN
  ,
  output logic          err
`endif
);

  localparam int SPW = $clog2(SD + 1);

  logic [AW-1:0]  upc_q, upc_d;
  logic [AW-1:0]  r_q, r_d;
  logic [AW-1:0]  tos;
  logic [AW-1:0]  y_mux;
  logic [SPW-1:0] stk_sp;
  logic           pass;
  logic           rnz;
  ctl_t           c;
  src_e           src;

  assign pass = ccen_n | ~cc_n;
  assign rnz  = |r_q;

  always_comb begin
    c = ctl_default();
    unique case (i)
      JZ: begin
        c.nsel = NA_ZERO;
        c.clr  = 1'b1;
      end
      CJS: begin
        if (pass) begin
          c.nsel = NA_D;
          c.push = 1'b1;
        end
      end
      JMAP: begin
        c.nsel = NA_D;
        c.src  = SRC_MAP;
      end
      CJP: begin
        if (pass) c.nsel = NA_D;
      end
      PUSH: begin
        c.push = 1'b1;
        c.r_ld = pass;
      end
      JSRP: begin
        c.push = 1'b1;
        c.nsel = pass ? NA_D : NA_R;
      end
      CJV: begin
        c.nsel = pass ? NA_D : NA_UPC;
        c.src  = SRC_VECT;
      end
      JRP: begin
        c.nsel = pass ? NA_D : NA_R;
      end
      RFCT: begin
        if (rnz) begin
          c.nsel  = NA_TOS;
          c.r_dec = 1'b1;
        end else begin
          c.pop = 1'b1;
        end
      end
      RPCT: begin
        if (rnz) begin
          c.nsel  = NA_D;
          c.r_dec = 1'b1;
        end
      end
      CRTN: begin
        if (pass) begin
          c.nsel = NA_TOS;
          c.pop  = 1'b1;
        end
      end
      CJPP: begin
        if (pass) begin
          c.nsel = NA_D;
          c.pop  = 1'b1;
        end
      end
      LDCT: begin
        c.r_ld = 1'b1;
      end
      LOOP: begin
        if (pass) c.pop = 1'b1;
        else      c.nsel = NA_TOS;
      end
      CONT: begin
        c.nsel = NA_UPC;
      end
      TWB: begin
        if (rnz && !pass) begin
          c.nsel  = NA_TOS;
          c.r_dec = 1'b1;
        end else if (!rnz && !pass) begin
          c.nsel = NA_D;
          c.pop  = 1'b1;
        end else begin
          c.pop = 1'b1;
        end
      end
      default: c = ctl_default();
    endcase
  end

  always_comb begin
    case (c.nsel)
      NA_ZERO: y_mux = '0;
      NA_D:    y_mux = d;
      NA_R:    y_mux = r_q;
      NA_TOS:  y_mux = tos;
      default: y_mux = upc_q;
    endcase
  end

  // Reset holds the address bus at zero and the pipeline source selected.
  assign y   = rst ? '0 : y_mux;
  assign src = rst ? SRC_PL : c.src;

  assign pl_n   = (src != SRC_PL);
  assign map_n  = (src != SRC_MAP);
  assign vect_n = (src != SRC_VECT);

  assign full_n = (stk_sp != SPW'(SD));

  assign upc_d = y + AW'(ci);

  // External load wins over both the conditional load and the decrement.
  always_comb begin
    r_d = r_q;
    if (!rld_n || c.r_ld) r_d = d;
    else if (c.r_dec)     r_d = r_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upc_q <= '0;
      r_q   <= '0;
    end else begin
      upc_q <= upc_d;
      r_q   <= r_d;
    end
  end

`ifdef AM4_USEQ_ERR_EN
  logic ovf;
  logic unf;
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (c.clr)          err_d = 1'b0;
    else if (ovf | unf) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

  am4_useq_stack #(
    .AW (AW),
    .SD (SD),
    .SPW(SPW)
  ) u_stack (
    .clk_i (clk),
    .rst_i (rst),
    .push_i(c.push),
    .pop_i (c.pop),
    .clr_i (c.clr),
    .din_i (upc_q),
    .tos_o (tos),
    .sp_o  (stk_sp)
`ifdef AM4_USEQ_ERR_EN
    ,
    .ovf_o (ovf),
    .unf_o (unf)
`endif
  );

endmodule

// File: tb/tb_am4_useq.sv
// tb_am4_useq: directed self-checking bench for am4_useq
// (checks err as well when AM4_USEQ_ERR_EN is defined).
module tb_am4_useq;
  import am4_useq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  i = CONT;
  logic [11:0] d = '0;
  logic        ccen_n = 1'b1;
  logic        cc_n = 1'b1;
  logic        ci = 1'b1;
  logic        rld_n = 1'b1;
  logic [11:0] y;
  logic        full_n;
  logic        pl_n;
  logic        map_n;
  logic        vect_n;
`ifdef AM4_USEQ_ERR_EN
  logic        err;
`endif

  int checks = 0;
  int errors = 0;

  am4_useq #(.AW(12), .SD(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .i     (i),
    .d     (d),
    .ccen_n(ccen_n),
    .cc_n  (cc_n),
    .ci    (ci),
    .rld_n (rld_n),
    .y     (y),
    .full_n(full_n),
    .pl_n  (pl_n),
    .map_n (map_n),
    .vect_n(vect_n)
`ifdef AM4_USEQ_ERR_EN
    ,
    .err   (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one instruction; ps = condition passes.
  task automatic set(input logic [3:0] op, input logic [11:0] dv,
                     input logic ps);
    i      = op;
    d      = dv;
    ccen_n = 1'b0;
    cc_n   = ~ps;
    #2;
  endtask

  task automatic step(input string tag, input logic [3:0] op,
                      input logic [11:0] dv, input logic ps,
                      input logic [11:0] ey);
    set(op, dv, ps);
    chk(tag, 16'(y), 16'(ey));
    tick();
  endtask

  task automatic do_reset();
    i = JMAP;
    d = 12'h777;
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_y", 16'(y), 16'h000);
    chk("rst_map_n", 16'(map_n), 16'h1);
    tick();
    tick();
    i     = CONT;
    ci    = 1'b1;
    rld_n = 1'b1;
    rst   = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state and CONT counting
    i = CONT;
    repeat (2) tick();
    chk("rst_y", 16'(y), 16'h000);
    chk("rst_full_n", 16'(full_n), 16'h1);
    chk("rst_pl_n", 16'(pl_n), 16'h0);
    chk("rst_map_n0", 16'(map_n), 16'h1);
    chk("rst_vect_n", 16'(vect_n), 16'h1);
    i = JMAP;
    d = 12'h555;
    #1;
    chk("rst_hold_y", 16'(y), 16'h000);
    chk("rst_hold_map", 16'(map_n), 16'h1);
    i   = CONT;
    rst = 1'b0;
    #1;
    chk("cont0", 16'(y), 16'h000);
    tick();
    chk("cont1", 16'(y), 16'h001);
    tick();
    chk("cont2", 16'(y), 16'h002);
    tick();
    chk("cont3", 16'(y), 16'h003);

    // Subroutine call / return
    do_reset();
    step("cjp_setup", CJP, 12'h00F, 1'b1, 12'h00F);
    step("cjs_pass", CJS, 12'h200, 1'b1, 12'h200);
    step("cjs_fail", CJS, 12'h300, 1'b0, 12'h201);
    step("crtn_fail", CRTN, 12'h000, 1'b0, 12'h202);
    step("crtn_pass", CRTN, 12'h000, 1'b1, 12'h010);
    step("cjs_again", CJS, 12'h040, 1'b1, 12'h040);
    step("crtn_sp0", CRTN, 12'h000, 1'b1, 12'h011);

    // Counter loops
    step("ldct", LDCT, 12'h003, 1'b0, 12'h012);
    step("rpct_r3", RPCT, 12'h050, 1'b0, 12'h050);
    step("rpct_r2", RPCT, 12'h050, 1'b0, 12'h050);
    step("rpct_r1", RPCT, 12'h050, 1'b0, 12'h050);
    step("rpct_r0", RPCT, 12'h050, 1'b0, 12'h051);
    rld_n = 1'b0;
    step("rpct_rld", RPCT, 12'h002, 1'b0, 12'h052);
    rld_n = 1'b1;
    step("rpct_after_rld", RPCT, 12'h050, 1'b0, 12'h050);
    step("rfct_r1", RFCT, 12'h000, 1'b0, 12'h011);
    step("rfct_r0", RFCT, 12'h000, 1'b0, 12'h012);
    step("ldct_1ab", LDCT, 12'h1AB, 1'b0, 12'h013);
    step("jrp_fail", JRP, 12'h222, 1'b0, 12'h1AB);
    step("jrp_pass", JRP, 12'h222, 1'b1, 12'h222);
    step("jsrp_fail", JSRP, 12'h333, 1'b0, 12'h1AB);
    step("jsrp_ret", CRTN, 12'h000, 1'b1, 12'h223);
    step("cjpp_pass", CJPP, 12'h0C0, 1'b1, 12'h0C0);
    step("cjpp_fail", CJPP, 12'h0D0, 1'b0, 12'h0C1);

    // Stack fill and overflow overwrite
    do_reset();
    step("cjp_020", CJP, 12'h01F, 1'b1, 12'h01F);
    for (int k = 0; k < 5; k++) begin
      step("push_n", PUSH, 12'h000, 1'b0, 12'(12'h020 + k));
      chk(k == 4 ? "full_n_5" : "full_n_lt5", 16'(full_n),
          k == 4 ? 16'h0 : 16'h1);
    end
    step("push_6", PUSH, 12'h000, 1'b0, 12'h025);
    chk("full_n_6", 16'(full_n), 16'h0);
    step("loop_fail_ovw", LOOP, 12'h000, 1'b0, 12'h025);
    step("loop_pass", LOOP, 12'h000, 1'b1, 12'h026);
    chk("full_n_pop", 16'(full_n), 16'h1);
    step("loop_fail_e3", LOOP, 12'h000, 1'b0, 12'h023);

    // TWB four ways
    do_reset();
    step("cjp_100", CJP, 12'h0FF, 1'b1, 12'h0FF);
    step("push_ld2", PUSH, 12'h002, 1'b1, 12'h100);
    step("twb_rnz_fail", TWB, 12'h300, 1'b0, 12'h100);
    step("twb_rnz_pass", TWB, 12'h300, 1'b1, 12'h101);
    step("rpct_r1_twb", RPCT, 12'h050, 1'b0, 12'h050);
    step("rpct_r0_twb", RPCT, 12'h050, 1'b0, 12'h051);
    step("twb_rz_fail", TWB, 12'h300, 1'b0, 12'h300);
    step("twb_rz_pass", TWB, 12'h300, 1'b1, 12'h301);
    step("jz", JZ, 12'h456, 1'b1, 12'h000);
    step("after_jz", CONT, 12'h000, 1'b0, 12'h001);

    // Source selects, wrap and carry-in
    set(JMAP, 12'h3AB, 1'b0);
    chk("jmap_y", 16'(y), 16'h3AB);
    chk("jmap_map_n", 16'(map_n), 16'h0);
    chk("jmap_pl_n", 16'(pl_n), 16'h1);
    chk("jmap_vect_n", 16'(vect_n), 16'h1);
    tick();
    set(CJV, 12'h0AA, 1'b1);
    chk("cjv_y", 16'(y), 16'h0AA);
    chk("cjv_vect_n", 16'(vect_n), 16'h0);
    chk("cjv_pl_n", 16'(pl_n), 16'h1);
    chk("cjv_map_n", 16'(map_n), 16'h1);
    tick();
    set(CJV, 12'h0DD, 1'b0);
    chk("cjv_fail_y", 16'(y), 16'h0AB);
    chk("cjv_fail_vect", 16'(vect_n), 16'h0);
    tick();
    set(CONT, 12'h000, 1'b0);
    chk("cont_pl_n", 16'(pl_n), 16'h0);
    tick();
    step("cjp_fff", CJP, 12'hFFF, 1'b1, 12'hFFF);
    step("wrap", CONT, 12'h000, 1'b0, 12'h000);
    ccen_n = 1'b1;
    i = CJP;
    d = 12'h123;
    #1;
    chk("ccen_force", 16'(y), 16'h123);
    ci = 1'b0;
    tick();
    step("ci0_hold", CONT, 12'h000, 1'b0, 12'h123);
    ci = 1'b1;

`ifdef AM4_USEQ_ERR_EN
    do_reset();
    chk("err_rst", 16'(err), 16'h0);
    step("unf_pop", CRTN, 12'h000, 1'b1, 12'h000);
    chk("err_set", 16'(err), 16'h1);
    step("err_sticky_c", CONT, 12'h000, 1'b0, 12'h001);
    chk("err_sticky", 16'(err), 16'h1);
    step("err_jz", JZ, 12'h000, 1'b0, 12'h000);
    chk("err_clr", 16'(err), 16'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
